pifo_reg_deq: RTL and testbench
===============================

# pifo_reg_deq

Dequeue-side controller for the register-based PIFO. It watches the PIFO's head (`valid_out`/`rank_out`/`meta_out`), issues single-cycle `remove` pulses when there is room downstream, and captures each removed entry into a small output FIFO. Downstream logic (egress scheduler / packet fetch) sees the entries, in rank order, through a valid/ready stream. Insertion stays upstream and drives the PIFO directly; this block only owns `remove`.

## Interface
- `RANK_WIDTH`, 8, rank width; must equal the PIFO's.
- `META_WIDTH`, 8, metadata width; must equal the PIFO's.
- `L2_DEPTH`, 1, log2 of output FIFO depth (DEPTH = 2**L2_DEPTH, L2_DEPTH >= 1).
- `clk`  in  1  single clock.
- `rst`  in  1  reset; synchronous, active-high.
- `enable`  in  1  dequeue permitted; when 0, no new removes are issued and the FIFO still drains.
- `pifo_valid`  in  1  PIFO `valid_out`.
- `pifo_rank`  in  RANK_WIDTH  PIFO `rank_out`.
- `pifo_meta`  in  META_WIDTH  PIFO `meta_out`.
- `pifo_remove`  out  1  to PIFO `remove`.
- `m_valid`  out  1  output entry valid.
- `m_ready`  in  1  downstream accepts.
- `m_rank`  out  RANK_WIDTH  head rank.
- `m_meta`  out  META_WIDTH  head meta.
- `level`  out  L2_DEPTH+1  output FIFO occupancy.
- `deq_count`  out  32  total removes issued; wraps modulo 2**32.

## Operation
- The FSM has 2 states: S_IDLE and S_SETTLE.
- In S_IDLE, `pifo_remove` is combinational and equals `enable & pifo_valid & (level < DEPTH) & ~rst`.
- When `pifo_remove`=1 in cycle t:
  - `{pifo_rank, pifo_meta}` sampled in cycle t are written into the FIFO tail at the t edge.
  - `deq_count` increments.
  - The FSM goes to S_SETTLE.
- S_SETTLE lasts exactly 1 cycle. `pifo_remove` is 0 and `pifo_valid` is ignored, because the PIFO's `valid_out` is stale for one cycle after a remove. The FSM then returns to S_IDLE.
- The PIFO gives remove priority over a same-cycle insert and latches the insert. The sampled head is therefore exactly the removed entry; no special handling is needed here.
- Output FIFO:
  - `m_valid` = (level != 0).
  - `m_rank`/`m_meta` show the head entry, and are forced to 0 when empty.
  - A pop occurs when `m_valid & m_ready`.
  - Push and pop in the same cycle leave `level` unchanged and keep order.
  - Pointers wrap modulo DEPTH.
- Full rule: the free-slot check uses `level` before any same-cycle pop. This is conservative, so a pop and a remove can never overflow the FIFO.
- `enable` falling while in S_SETTLE has no effect on an already-issued remove. No further removes are issued.
- Reset values:
  - state S_IDLE, FIFO empty, `level`=0, `deq_count`=0.
  - `m_valid`=0, `m_rank`=0, `m_meta`=0, `pifo_remove`=0.
- Reset mid-operation: any FIFO contents and the S_SETTLE state are discarded. Entries already removed from the PIFO are lost; this is accepted.

## Timing
- The PIFO head valid in cycle t, with space and `enable`, gives `pifo_remove`=1 in the same cycle t.
- The entry appears at `m_valid`/`m_rank`/`m_meta` in cycle t+1 if the FIFO was empty.
- Maximum remove rate is 1 per 2 cycles (remove, settle). The next remove is at t+2 at the earliest, and only if the PIFO re-asserts `valid_out` by then.
- Removes only ever occur in S_IDLE. `pifo_remove` is never high in two consecutive cycles.
- The output stream can sustain 1 pop per cycle while the FIFO is non-empty.
- `deq_count` and `level` are registered. They update at the edge closing the cycle of the event.

## Test plan
- **Reset:** hold `rst` 3 cycles with `pifo_valid`=1 and `enable`=1 → `pifo_remove`=0, `m_valid`=0, `level`=0, `deq_count`=0 throughout. After release, the first remove occurs in the first cycle with `pifo_valid`=1.
- **Single entry:** PIFO model holding rank 5 / meta 0x11, `m_ready`=1.
  - `pifo_remove` pulses at t.
  - At t+1: `m_valid`=1, `m_rank`=5, `m_meta`=0x11; `deq_count`=1.
  - At t+2: `m_valid`=0.
- **Ordering/rate:** PIFO model preloaded with ranks 9, 3, 7, `m_ready`=1 → removes at t, t+2, t+4; output ranks 3, 7, 9; `deq_count`=3.
- **Backpressure:** L2_DEPTH=1, `m_ready`=0, 4 entries in the PIFO.
  - Exactly 2 removes occur; `level`=2; `pifo_remove` stays 0 although `pifo_valid`=1.
  - Raising `m_ready` for 1 cycle pops 1 entry. The next remove occurs 1 cycle later.
- **Enable:** `enable`=0 with 2 buffered entries and a valid PIFO head → no removes; the FIFO drains to 0. Re-asserting `enable` removes in the same cycle.
- **Mid-operation reset:** assert `rst` in S_SETTLE with `level`=1 → next cycle `level`=0, `m_valid`=0, `deq_count`=0, and the FSM is in S_IDLE.

Source files
------------

// File: rtl/pifo_reg_deq.sv
// pifo_reg_deq: dequeue-side controller for the register-based PIFO.
// Pulls entries off the PIFO head one remove at a time, waits one settle
// cycle for the PIFO's head to refresh, and buffers removed entries in a
// small output FIFO exposed as a valid/ready stream.
//
// state    | meaning
// ---------+------------------------------------------------------------
// S_IDLE   | may issue a remove when the head is valid, enabled, not full
// S_SETTLE | remove just issued; PIFO valid_out is stale, hold off 1 cycle
module pifo_reg_deq #(
    parameter int RANK_WIDTH = 8,
    parameter int META_WIDTH = 8,
    parameter int L2_DEPTH   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  pifo_valid,
    input  logic [RANK_WIDTH-1:0] pifo_rank,
    input  logic [META_WIDTH-1:0] pifo_meta,
    output logic                  pifo_remove,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [RANK_WIDTH-1:0] m_rank,
    output logic [META_WIDTH-1:0] m_meta,
    output logic [L2_DEPTH:0]     level,
    output logic [31:0]           deq_count
);

    localparam int                DEPTH     = 1 << L2_DEPTH;
    localparam logic [L2_DEPTH:0] DEPTH_LVL = DEPTH[L2_DEPTH:0];

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_SETTLE = 1'b1
    } state_t;

    state_t                state;
    logic [RANK_WIDTH-1:0] rank_mem [DEPTH];
    logic [META_WIDTH-1:0] meta_mem [DEPTH];
    logic [L2_DEPTH-1:0]   wr_ptr;
    logic [L2_DEPTH-1:0]   rd_ptr;
    logic                  push;
    logic                  pop;

    // Full check uses the pre-pop level so a same-cycle pop can never be
    // relied on to make room; this keeps the FIFO overflow-proof.
    assign pifo_remove = (state == S_IDLE) & enable & pifo_valid
                         & (level < DEPTH_LVL) & ~rst;

    assign push    = pifo_remove;
    assign m_valid = (level != '0);
    assign pop     = m_valid & m_ready;
    assign m_rank  = m_valid ? rank_mem[rd_ptr] : '0;
    assign m_meta  = m_valid ? meta_mem[rd_ptr] : '0;

    // Remove/settle sequencing: every remove is followed by one blind cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (pifo_remove) state <= S_SETTLE;
                S_SETTLE: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // FIFO storage: the sampled head is exactly the removed entry.
    always_ff @(posedge clk) begin
        if (push) begin
            rank_mem[wr_ptr] <= pifo_rank;
            meta_mem[wr_ptr] <= pifo_meta;
        end
    end

    // FIFO pointers and occupancy; push+pop together leaves level unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Running count of removes issued, wrapping naturally at 2**32.
    always_ff @(posedge clk) begin
        if (rst) begin
            deq_count <= '0;
        end else if (pifo_remove) begin
            deq_count <= deq_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pifo_reg_deq.sv
// Directed bench for pifo_reg_deq: cycle table plus hand sequences for
// reset, mid-operation reset and ordering through a small PIFO model.
module tb_pifo_reg_deq;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        pifo_valid;
    logic [7:0]  pifo_rank;
    logic [7:0]  pifo_meta;
    logic        pifo_remove;
    logic        m_valid;
    logic        m_ready;
    logic [7:0]  m_rank;
    logic [7:0]  m_meta;
    logic [1:0]  level;
    logic [31:0] deq_count;

    int n_vec = 0;
    int n_err = 0;

    pifo_reg_deq #(.RANK_WIDTH(8), .META_WIDTH(8), .L2_DEPTH(1)) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pifo_valid(pifo_valid), .pifo_rank(pifo_rank), .pifo_meta(pifo_meta),
        .pifo_remove(pifo_remove), .m_valid(m_valid), .m_ready(m_ready),
        .m_rank(m_rank), .m_meta(m_meta), .level(level), .deq_count(deq_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        en;
        logic        pv;
        logic [7:0]  rank;
        logic [7:0]  meta;
        logic        rdy;
        logic        rem;
        logic        mv;
        logic [7:0]  mrank;
        logic [7:0]  mmeta;
        logic [1:0]  lvl;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en, pv, input logic [7:0] rank, meta,
                                input logic rdy, rem, mv, input logic [7:0] mrank, mmeta,
                                input logic [1:0] lvl, input logic [31:0] cnt);
        vec_t v;
        v.en = en; v.pv = pv; v.rank = rank; v.meta = meta; v.rdy = rdy;
        v.rem = rem; v.mv = mv; v.mrank = mrank; v.mmeta = mmeta;
        v.lvl = lvl; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%0d] got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input vec_t v);
        chk("pifo_remove", idx, {31'd0, pifo_remove}, {31'd0, v.rem});
        chk("m_valid",     idx, {31'd0, m_valid},     {31'd0, v.mv});
        chk("m_rank",      idx, {24'd0, m_rank},      {24'd0, v.mrank});
        chk("m_meta",      idx, {24'd0, m_meta},      {24'd0, v.mmeta});
        chk("level",       idx, {30'd0, level},       {30'd0, v.lvl});
        chk("deq_count",   idx, deq_count,            v.cnt);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; enable = 1'b1; pifo_valid = 1'b0; m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // small PIFO model: kept sorted by rank, head at index 0
    logic [7:0] q_rank[$];
    logic [7:0] q_meta[$];

    task automatic pifo_insert(input logic [7:0] r, m);
        int pos = q_rank.size();
        for (int i = 0; i < q_rank.size(); i++) begin
            if (r < q_rank[i]) begin
                pos = i;
                break;
            end
        end
        q_rank.insert(pos, r);
        q_meta.insert(pos, m);
    endtask

    initial begin
        int         rem_cyc[$];
        logic [7:0] got_rank[$];
        logic [7:0] got_meta[$];
        int         exp_cyc[3]    = '{0, 2, 4};
        logic [7:0] exp_rank[3]   = '{8'd3, 8'd7, 8'd9};
        logic [7:0] exp_meta[3]   = '{8'h30, 8'h70, 8'h90};
        vec_t       rv;

        rst = 1'b1; enable = 1'b1; pifo_valid = 1'b1;
        pifo_rank = 8'h05; pifo_meta = 8'h11; m_ready = 1'b0;

        // reset held 3 cycles with a valid head and enable: nothing moves
        rv = mk(1, 1, 8'h05, 8'h11, 0, 0, 0, 8'h00, 8'h00, 2'd0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check_all(100 + i, rv);
        end

        //           en pv rank   meta   rdy rem mv mrank  mmeta  lvl cnt
        vecs.push_back(mk(1, 1, 8'h05, 8'h11, 0, 1, 0, 8'h00, 8'h00, 0, 0));
        vecs.push_back(mk(1, 1, 8'h06, 8'h22, 0, 0, 1, 8'h05, 8'h11, 1, 1));
        vecs.push_back(mk(1, 1, 8'h06, 8'h22, 0, 1, 1, 8'h05, 8'h11, 1, 1));
        vecs.push_back(mk(1, 1, 8'h07, 8'h33, 0, 0, 1, 8'h05, 8'h11, 2, 2));
        vecs.push_back(mk(1, 1, 8'h07, 8'h33, 0, 0, 1, 8'h05, 8'h11, 2, 2));
        vecs.push_back(mk(1, 1, 8'h07, 8'h33, 1, 0, 1, 8'h05, 8'h11, 2, 2));
        vecs.push_back(mk(1, 1, 8'h07, 8'h33, 0, 1, 1, 8'h06, 8'h22, 1, 2));
        vecs.push_back(mk(0, 1, 8'h08, 8'h44, 1, 0, 1, 8'h06, 8'h22, 2, 3));
        vecs.push_back(mk(0, 1, 8'h08, 8'h44, 1, 0, 1, 8'h07, 8'h33, 1, 3));
        vecs.push_back(mk(0, 1, 8'h08, 8'h44, 1, 0, 0, 8'h00, 8'h00, 0, 3));
        vecs.push_back(mk(1, 1, 8'h08, 8'h44, 1, 1, 0, 8'h00, 8'h00, 0, 3));
        vecs.push_back(mk(1, 1, 8'h09, 8'h55, 1, 0, 1, 8'h08, 8'h44, 1, 4));
        vecs.push_back(mk(1, 0, 8'h09, 8'h55, 1, 0, 0, 8'h00, 8'h00, 0, 4));
        vecs.push_back(mk(1, 1, 8'h09, 8'h55, 1, 1, 0, 8'h00, 8'h00, 0, 4));
        vecs.push_back(mk(1, 1, 8'h0a, 8'h66, 1, 0, 1, 8'h09, 8'h55, 1, 5));
        vecs.push_back(mk(1, 1, 8'h0a, 8'h66, 1, 1, 0, 8'h00, 8'h00, 0, 5));
        vecs.push_back(mk(1, 1, 8'h0b, 8'h77, 0, 0, 1, 8'h0a, 8'h66, 1, 6));
        vecs.push_back(mk(1, 1, 8'h0b, 8'h77, 1, 1, 1, 8'h0a, 8'h66, 1, 6));
        vecs.push_back(mk(1, 0, 8'h0b, 8'h77, 1, 0, 1, 8'h0b, 8'h77, 1, 7));
        vecs.push_back(mk(1, 0, 8'h0b, 8'h77, 0, 0, 0, 8'h00, 8'h00, 0, 7));

        // table starts in the first cycle after reset release
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = 1'b0;
            enable = vecs[i].en; pifo_valid = vecs[i].pv;
            pifo_rank = vecs[i].rank; pifo_meta = vecs[i].meta;
            m_ready = vecs[i].rdy;
            #1;
            check_all(i, vecs[i]);
        end

        // mid-operation reset while settling with one buffered entry
        @(negedge clk);
        enable = 1'b1; pifo_valid = 1'b1; pifo_rank = 8'h21; pifo_meta = 8'h42; m_ready = 1'b0;
        #1;
        chk("midrst_remove", 0, {31'd0, pifo_remove}, 32'd1);
        @(negedge clk);
        #1;
        chk("midrst_settle_level", 0, {30'd0, level}, 32'd1);
        chk("midrst_settle_remove", 0, {31'd0, pifo_remove}, 32'd0);
        rst = 1'b1;
        #1;
        chk("midrst_rst_remove", 0, {31'd0, pifo_remove}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_level", 0, {30'd0, level}, 32'd0);
        chk("midrst_m_valid", 0, {31'd0, m_valid}, 32'd0);
        chk("midrst_deq_count", 0, deq_count, 32'd0);
        chk("midrst_idle_remove", 0, {31'd0, pifo_remove}, 32'd1);

        // ordering and rate through a PIFO model preloaded with 9, 3, 7
        do_reset();
        q_rank.delete(); q_meta.delete();
        pifo_insert(8'd9, 8'h90);
        pifo_insert(8'd3, 8'h30);
        pifo_insert(8'd7, 8'h70);
        for (int c = 0; c < 12; c++) begin
            if (c > 0) @(negedge clk);
            m_ready    = 1'b1;
            enable     = 1'b1;
            pifo_valid = (q_rank.size() > 0);
            pifo_rank  = (q_rank.size() > 0) ? q_rank[0] : 8'h00;
            pifo_meta  = (q_meta.size() > 0) ? q_meta[0] : 8'h00;
            #1;
            if (m_valid && m_ready) begin
                got_rank.push_back(m_rank);
                got_meta.push_back(m_meta);
            end
            if (pifo_remove) begin
                rem_cyc.push_back(c);
                void'(q_rank.pop_front());
                void'(q_meta.pop_front());
            end
        end
        chk("order_removes", 0, rem_cyc.size(), 32'd3);
        chk("order_pops", 0, got_rank.size(), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < rem_cyc.size()) chk("order_rem_cycle", k, rem_cyc[k], exp_cyc[k]);
            if (k < got_rank.size()) begin
                chk("order_rank", k, {24'd0, got_rank[k]}, {24'd0, exp_rank[k]});
                chk("order_meta", k, {24'd0, got_meta[k]}, {24'd0, exp_meta[k]});
            end
        end
        chk("order_deq_count", 0, deq_count, 32'd3);
        chk("order_drained", 0, {31'd0, m_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
